// File: rtl/button_pulse_gen_pkg.sv
// Shared game definitions: game-state constants plus the button
// conditioning state encoding and default debounce timing.
package button_pulse_gen_pkg;

  // Top-level game flow states consumed by the game state machine.
  typedef enum logic [1:0] {
    GAME_IDLE  = 2'd0,
    GAME_PLAY  = 2'd1,
    GAME_PAUSE = 2'd2,
    GAME_OVER  = 2'd3
  } game_state_t;

  // Per-channel button conditioning states.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // 10 ms of stable level at 100 MHz before a change is accepted.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int CNT_W_DEFAULT           = 20;

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchronizer, saturating qualification
// counter and a 4-state press/release FSM with registered strobes.
module button_debounce
  import button_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic OriginalClk,
  input  logic reset,
  input  logic i_btnRaw,
  output logic o_btnLevel,
  output logic o_btnPulse,
  output logic o_btnRelease
);

  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic             w_sync;
  btn_state_t       r_state;
  btn_state_t       w_nextState;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_nextCount;
  logic             w_pressDone;
  logic             w_releaseDone;
  logic             r_pressDone;
  logic             r_releaseDone;
  logic             r_level;
  logic             r_pulse;
  logic             r_release;

  assign w_sync = r_sync2;

  // Bring the asynchronous pad level into the clock domain.
  always_ff @(posedge OriginalClk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btnRaw;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state, qualification counter and the completed-transition flags.
  always_ff @(posedge OriginalClk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_pressDone   <= 1'b0;
      r_releaseDone <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_count       <= w_nextCount;
      r_pressDone   <= w_pressDone;
      r_releaseDone <= w_releaseDone;
    end
  end

  // Next state: a level change must hold for DEBOUNCE_CYCLES synced samples;
  // any reversal during qualification falls back without a strobe.
  always_comb begin
    w_nextState   = r_state;
    w_nextCount   = r_count;
    w_pressDone   = 1'b0;
    w_releaseDone = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sync) begin
          w_nextState = PRESS_WAIT;
          w_nextCount = ONE;
        end
      end
      PRESS_WAIT: begin
        if (!w_sync) begin
          w_nextState = IDLE;
          w_nextCount = '0;
        end else if (r_count >= TERMINAL) begin
          w_nextState = PRESSED;
          w_nextCount = '0;
          w_pressDone = 1'b1;
        end else begin
          w_nextCount = r_count + ONE;
        end
      end
      PRESSED: begin
        if (!w_sync) begin
          w_nextState = RELEASE_WAIT;
          w_nextCount = ONE;
        end
      end
      RELEASE_WAIT: begin
        if (w_sync) begin
          w_nextState = PRESSED;
          w_nextCount = '0;
        end else if (r_count >= TERMINAL) begin
          w_nextState   = IDLE;
          w_nextCount   = '0;
          w_releaseDone = 1'b1;
        end else begin
          w_nextCount = r_count + ONE;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextCount = '0;
      end
    endcase
  end

  // Output stage: strobes and level change together, one register after the FSM.
  always_ff @(posedge OriginalClk or posedge reset) begin
    if (reset) begin
      r_level   <= 1'b0;
      r_pulse   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_pulse   <= r_pressDone;
      r_release <= r_releaseDone;
      if (r_pressDone) begin
        r_level <= 1'b1;
      end else if (r_releaseDone) begin
        r_level <= 1'b0;
      end
    end
  end

  assign o_btnLevel   = r_level;
  assign o_btnPulse   = r_pulse;
  assign o_btnRelease = r_release;

endmodule

// File: rtl/button_pulse_gen.sv
// Conditions NUM_BTN raw push-buttons into debounced levels and
// single-cycle press/release strobes; channels are fully independent.
module button_pulse_gen
  import button_pulse_gen_pkg::*;
#(
  parameter int NUM_BTN         = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic               OriginalClk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_BTN-1:0] btn_release
);

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .OriginalClk (OriginalClk),
      .reset       (reset),
      .i_btnRaw    (btn_raw[gi]),
      .o_btnLevel  (btn_level[gi]),
      .o_btnPulse  (btn_pulse[gi]),
      .o_btnRelease(btn_release[gi])
    );
  end

endmodule
